mc_control: RTL and testbench

MC_CONTROL -- requirements
Module: mc_control

---
 rtl/mc_control_pkg.sv | 68 ++++++
 rtl/mc_decode.sv | 55 +++++
 rtl/mc_control.sv | 215 +++++++++++++++++++++
 tb/tb_mc_control.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_control_pkg.sv
// ---------------------------------------------------------------------------
// mc_control_pkg
// Shared definitions for the multicycle controller: FSM state encodings,
// RV32 opcode constants, the instruction-class enum produced by mc_decode,
// and the datapath select encodings (imm_sel, alu_src_b, alu_op, pc_src,
// wb_sel). No ports.
// ---------------------------------------------------------------------------
package mc_control_pkg;

    // Controller states. Encodings are visible on the debug 'state' port.
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_FAULT  = 3'd7
    } state_t;

    // Opcodes (ir[6:0]) understood by the controller.
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_RALU   = 7'b0110011;

    // Instruction class, derived from the opcode only.
    typedef enum logic [2:0] {
        CLS_ILLEGAL = 3'd0,
        CLS_LOAD    = 3'd1,
        CLS_STORE   = 3'd2,
        CLS_BRANCH  = 3'd3,
        CLS_RALU    = 3'd4,
        CLS_IALU    = 3'd5,
        CLS_JAL     = 3'd6
    } iclass_t;

    // Immediate generator format select.
    localparam logic [2:0] IMM_I    = 3'b000;
    localparam logic [2:0] IMM_S    = 3'b001;
    localparam logic [2:0] IMM_B    = 3'b010;
    localparam logic [2:0] IMM_J    = 3'b011;
    localparam logic [2:0] IMM_NONE = 3'b111;

    // ALU operand B source.
    localparam logic [1:0] SRCB_REG = 2'b00;
    localparam logic [1:0] SRCB_IMM = 2'b01;

    // ALU operation class.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Next-PC source.
    localparam logic [1:0] PCSRC_PLUS4  = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Register write-back source.
    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    // addi x0, x0, 0 -- instruction register contents out of reset.
    localparam logic [31:0] IR_NOP = 32'h0000_0013;

endpackage

// File: rtl/mc_decode.sv
// ---------------------------------------------------------------------------
// mc_decode
// Combinational opcode-to-class decoder for the multicycle controller.
//   opcode  in  7  ir[6:0]
//   iclass  out    instruction class (CLS_ILLEGAL for unsupported opcodes)
//   imm_sel out 3  immediate format for that class (IMM_NONE if none)
// Build option: MC_CONTROL_JAL_EN -- when defined, JAL decodes as a J-type
// jump; otherwise its opcode is treated as illegal.
// ---------------------------------------------------------------------------
module mc_decode
    import mc_control_pkg::*;
(
    input  logic [6:0] opcode,
    output iclass_t    iclass,
    output logic [2:0] imm_sel
);

    always_comb begin
        iclass  = CLS_ILLEGAL;
        imm_sel = IMM_NONE;
        case (opcode)
            OP_LOAD: begin
                iclass  = CLS_LOAD;
                imm_sel = IMM_I;
            end
            OP_IALU: begin
                iclass  = CLS_IALU;
                imm_sel = IMM_I;
            end
            OP_STORE: begin
                iclass  = CLS_STORE;
                imm_sel = IMM_S;
            end
            OP_BRANCH: begin
                iclass  = CLS_BRANCH;
                imm_sel = IMM_B;
            end
            OP_RALU: begin
                iclass  = CLS_RALU;
                imm_sel = IMM_NONE;
            end
`ifdef MC_CONTROL_JAL_EN
            OP_JAL: begin
                iclass  = CLS_JAL;
                imm_sel = IMM_J;
            end
`endif
            default: begin
                iclass  = CLS_ILLEGAL;
                imm_sel = IMM_NONE;
            end
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// ---------------------------------------------------------------------------
// mc_control
// Multicycle RV32 subset controller: FETCH -> DECODE -> EXEC -> [MEM] -> [WB].
// Parameter MEM_TIMEOUT (1..255): consecutive un-acked memory-wait cycles
// in FETCH or MEM before the controller enters the sticky FAULT state.
// Build option: MC_CONTROL_JAL_EN enables JAL (EXEC writes PC, WB writes
// PC+4 to rd); without it JAL is an illegal opcode.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   mem_rdata[31:0], mem_ready   memory read data and acknowledge
//   alu_zero                     ALU zero flag (branch condition)
//   mem_req, mem_we, mem_addr_sel memory request/write/address source
//   ir[31:0]                     latched instruction
//   imm_sel[2:0]                 immediate format
//   alu_src_b, alu_op, pc_src, wb_sel [1:0] datapath selects
//   pc_write, reg_write, instr_done, fault   strobes / status
//   state[2:0]                   current FSM state (debug)
// ---------------------------------------------------------------------------
module mc_control
    import mc_control_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    input  logic        alu_zero,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic [31:0] ir,
    output logic [2:0]  imm_sel,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  pc_src,
    output logic [1:0]  wb_sel,
    output logic        pc_write,
    output logic        reg_write,
    output logic        instr_done,
    output logic        fault,
    output logic [2:0]  state
);

    // Value the wait counter holds during the last allowed wait cycle.
    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      state_reg, state_next;
    logic [31:0] ir_reg;
    logic [7:0]  wait_cnt_reg, wait_cnt_next;
    iclass_t     dec_class;
    logic [2:0]  dec_imm_sel;
    logic        mem_wait;
    logic        timeout;

    // ir is stable from DECODE until the next FETCH acknowledge, so the
    // decoder output is valid for every post-fetch state.
    mc_decode u_decode (
        .opcode  (ir_reg[6:0]),
        .iclass  (dec_class),
        .imm_sel (dec_imm_sel)
    );

    // A memory-wait cycle: a request is outstanding and not acknowledged.
    assign mem_wait = ((state_reg == ST_FETCH) || (state_reg == ST_MEM)) && !mem_ready;
    assign timeout  = mem_wait && (wait_cnt_reg == TIMEOUT_LAST);

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_FETCH;
            ir_reg       <= IR_NOP;
            wait_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            if ((state_reg == ST_FETCH) && mem_ready) begin
                ir_reg <= mem_rdata;
            end
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_FETCH: begin
                if (mem_ready) begin
                    state_next = ST_DECODE;
                end else if (timeout) begin
                    state_next = ST_FAULT;
                end
            end
            ST_DECODE: begin
                state_next = (dec_class == CLS_ILLEGAL) ? ST_FAULT : ST_EXEC;
            end
            ST_EXEC: begin
                case (dec_class)
                    CLS_LOAD, CLS_STORE:         state_next = ST_MEM;
                    CLS_BRANCH:                  state_next = ST_FETCH;
                    CLS_RALU, CLS_IALU, CLS_JAL: state_next = ST_WB;
                    default:                     state_next = ST_FAULT;
                endcase
            end
            ST_MEM: begin
                if (mem_ready) begin
                    state_next = (dec_class == CLS_STORE) ? ST_FETCH : ST_WB;
                end else if (timeout) begin
                    state_next = ST_FAULT;
                end
            end
            ST_WB:    state_next = ST_FETCH;
            ST_FAULT: state_next = ST_FAULT;
            // Unused encodings are treated as a fault rather than silently
            // resuming execution.
            default:  state_next = ST_FAULT;
        endcase
    end

    // Wait counter restarts whenever the state changes or the memory answers.
    always_comb begin
        if ((state_next != state_reg) || !mem_wait) begin
            wait_cnt_next = '0;
        end else begin
            wait_cnt_next = wait_cnt_reg + 8'd1;
        end
    end

    // ---------------- output logic ----------------
    // Outputs are additionally qualified with rst_n so that an asserted
    // reset forces every strobe low immediately, even though the held
    // reset state (FETCH) would otherwise request memory.
    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        imm_sel      = IMM_NONE;
        alu_src_b    = SRCB_REG;
        alu_op       = ALUOP_ADD;
        pc_src       = PCSRC_PLUS4;
        wb_sel       = WB_ALU;
        pc_write     = 1'b0;
        reg_write    = 1'b0;
        instr_done   = 1'b0;
        fault        = 1'b0;
        if (rst_n) begin
            case (state_reg)
                ST_FETCH: begin
                    mem_req  = 1'b1;
                    pc_write = mem_ready;     // PC <= PC+4 on the fetch acknowledge
                end
                ST_DECODE: begin
                    imm_sel = dec_imm_sel;
                end
                ST_EXEC: begin
                    imm_sel = dec_imm_sel;
                    case (dec_class)
                        CLS_LOAD, CLS_STORE: begin
                            alu_src_b = SRCB_IMM;
                            alu_op    = ALUOP_ADD;
                        end
                        CLS_IALU: begin
                            alu_src_b = SRCB_IMM;
                            alu_op    = ALUOP_FUNCT;
                        end
                        CLS_RALU: begin
                            alu_src_b = SRCB_REG;
                            alu_op    = ALUOP_FUNCT;
                        end
                        CLS_BRANCH: begin
                            alu_src_b  = SRCB_REG;
                            alu_op     = ALUOP_SUB;
                            pc_src     = PCSRC_BRANCH;
                            pc_write   = alu_zero;
                            instr_done = 1'b1;
                        end
                        CLS_JAL: begin
                            pc_src   = PCSRC_JUMP;
                            pc_write = 1'b1;
                        end
                        default: ;
                    endcase
                end
                ST_MEM: begin
                    imm_sel      = dec_imm_sel;
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    mem_we       = (dec_class == CLS_STORE);
                    instr_done   = mem_ready && (dec_class == CLS_STORE);
                end
                ST_WB: begin
                    imm_sel    = dec_imm_sel;
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                    if (dec_class == CLS_LOAD) begin
                        wb_sel = WB_MEM;
                    end else if (dec_class == CLS_JAL) begin
                        wb_sel = WB_PC4;
                    end else begin
                        wb_sel = WB_ALU;
                    end
                end
                ST_FAULT: begin
                    fault = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign ir    = ir_reg;
    assign state = state_reg;

endmodule

// File: tb/tb_mc_control.sv
// ---------------------------------------------------------------------------
// tb_mc_control
// Directed bench for mc_control: a per-cycle vector table for a stream of
// zero-wait instructions, then hand-written sequences for wait states,
// timeout, illegal opcodes, JAL and mid-transaction reset.
// ---------------------------------------------------------------------------
module tb_mc_control;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] LW   = 32'h0040_2083;
    localparam logic [31:0] BEQ  = 32'h0020_8463;
    localparam logic [31:0] ADD  = 32'h0020_81B3;
    localparam logic [31:0] ADDI = 32'h0050_0093;
    localparam logic [31:0] SW   = 32'h0011_2223;
    localparam logic [31:0] JAL  = 32'h0080_00EF;
    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ready = 1'b0;
    logic        alu_zero = 1'b0;
    logic        mem_req, mem_we, mem_addr_sel;
    logic [31:0] ir;
    logic [2:0]  imm_sel;
    logic [1:0]  alu_src_b, alu_op, pc_src, wb_sel;
    logic        pc_write, reg_write, instr_done, fault;
    logic [2:0]  state;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mc_control #(.MEM_TIMEOUT(15)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .alu_zero     (alu_zero),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir           (ir),
        .imm_sel      (imm_sel),
        .alu_src_b    (alu_src_b),
        .alu_op       (alu_op),
        .pc_src       (pc_src),
        .wb_sel       (wb_sel),
        .pc_write     (pc_write),
        .reg_write    (reg_write),
        .instr_done   (instr_done),
        .fault        (fault),
        .state        (state)
    );

    typedef struct {
        logic        rdy;
        logic [31:0] rdata;
        logic        zero;
        logic [2:0]  st;
        logic        req, we, asel;
        logic [2:0]  imm;
        logic [1:0]  srcb, aop, psrc, wsel;
        logic        pcw, rw, done;
        logic [31:0] ir;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] snap();
        return {11'd0, ir, state, mem_req, mem_we, mem_addr_sel, imm_sel,
                alu_src_b, alu_op, pc_src, wb_sel, pc_write, reg_write, instr_done, fault};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at the drive point of the first cycle after reset.
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        mem_ready = 1'b0;
        alu_zero = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Zero-wait fetch; leaves the bench at the drive point of DECODE.
    task automatic fetch(input logic [31:0] instr);
        mem_ready = 1'b1;
        mem_rdata = instr;
        step();
        mem_ready = 1'b0;
        mem_rdata = JUNK;
    endtask

    // Holds mem_ready low for MEM_TIMEOUT cycles in state st, then expects FAULT.
    task automatic stuck_to_fault(input logic [2:0] st, input string name);
        int bad;
        bad = 0;
        mem_ready = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (state !== st) bad++;
            step();
        end
        check({name, "_held_15"}, 64'(bad), 64'd0);
        @(negedge clk);
        check({name, "_fault"}, 64'({state, fault, mem_req, mem_we}), 64'({3'd7, 1'b1, 1'b0, 1'b0}));
        $display("seq %s: state=%0d fault=%0b", name, state, fault);
    endtask

    initial begin
        int req_we, asel_n, done_n, bad;

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", snap(), {11'd0, NOP, 3'd0, 3'b000, 3'd7, 8'd0, 4'b0000});
        do_reset();

        // ---- per-cycle table: rdy rdata zero | st req we asel imm srcb aop psrc wsel pcw rw done ir ----
        // lw
        vecs.push_back('{1'b1, LW,   1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 3'd7, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, NOP});
        vecs.push_back('{1'b1, JUNK, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, LW});
        vecs.push_back('{1'b1, JUNK, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 3'd0, 2'd1, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, LW});
        vecs.push_back('{1'b1, JUNK, 1'b0, 3'd3, 1'b1, 1'b0, 1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, LW});
        vecs.push_back('{1'b1, JUNK, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 2'd0, 2'd1, 1'b0, 1'b1, 1'b1, LW});
        // beq, taken
        vecs.push_back('{1'b1, BEQ,  1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 3'd7, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, LW});
        vecs.push_back('{1'b1, JUNK, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 3'd2, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, BEQ});
        vecs.push_back('{1'b1, JUNK, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 3'd2, 2'd0, 2'd1, 2'd1, 2'd0, 1'b1, 1'b0, 1'b1, BEQ});
        // beq, not taken
        vecs.push_back('{1'b1, BEQ,  1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 3'd7, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, BEQ});
        vecs.push_back('{1'b1, JUNK, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 3'd2, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, BEQ});
        vecs.push_back('{1'b1, JUNK, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 3'd2, 2'd0, 2'd1, 2'd1, 2'd0, 1'b0, 1'b0, 1'b1, BEQ});
        // add (R-type)
        vecs.push_back('{1'b1, ADD,  1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 3'd7, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, BEQ});
        vecs.push_back('{1'b1, JUNK, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 3'd7, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, ADD});
        vecs.push_back('{1'b1, JUNK, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 3'd7, 2'd0, 2'd2, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, ADD});
        vecs.push_back('{1'b1, JUNK, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0, 3'd7, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b1, ADD});
        // addi (I-ALU)
        vecs.push_back('{1'b1, ADDI, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 3'd7, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, ADD});
        vecs.push_back('{1'b1, JUNK, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, ADDI});
        vecs.push_back('{1'b1, JUNK, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 3'd0, 2'd1, 2'd2, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, ADDI});
        vecs.push_back('{1'b1, JUNK, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b1, ADDI});
        // sw
        vecs.push_back('{1'b1, SW,   1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 3'd7, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, ADDI});
        vecs.push_back('{1'b1, JUNK, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 3'd1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, SW});
        vecs.push_back('{1'b1, JUNK, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 3'd1, 2'd1, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, SW});
        vecs.push_back('{1'b1, JUNK, 1'b0, 3'd3, 1'b1, 1'b1, 1'b1, 3'd1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, SW});
        // next fetch, memory not ready yet
        vecs.push_back('{1'b0, JUNK, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 3'd7, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, SW});

        foreach (vecs[i]) begin
            mem_ready = vecs[i].rdy;
            mem_rdata = vecs[i].rdata;
            alu_zero  = vecs[i].zero;
            @(negedge clk);
            check($sformatf("vec%0d", i), snap(),
                  {11'd0, vecs[i].ir, vecs[i].st, vecs[i].req, vecs[i].we, vecs[i].asel, vecs[i].imm,
                   vecs[i].srcb, vecs[i].aop, vecs[i].psrc, vecs[i].wsel,
                   vecs[i].pcw, vecs[i].rw, vecs[i].done, 1'b0});
            $display("vec %0d: state=%0d outs=%h", i, state, snap());
            step();
        end

        // ---- sw with mem_ready delayed 3 cycles in MEM ----
        do_reset();
        fetch(SW);
        req_we = 0; asel_n = 0; done_n = 0;
        for (int k = 0; k < 6; k++) begin
            mem_ready = (k == 0) || (k == 5);   // k==0 is DECODE: must be ignored
            @(negedge clk);
            if (mem_req && mem_we) req_we++;
            if (mem_addr_sel) asel_n++;
            if (instr_done) done_n++;
            step();
        end
        mem_ready = 1'b0;
        check("sw_req_we_cycles", 64'(req_we), 64'd4);
        check("sw_addr_sel_cycles", 64'(asel_n), 64'd4);
        check("sw_instr_done_count", 64'(done_n), 64'd1);
        @(negedge clk);
        check("sw_back_to_fetch", 64'(state), 64'd0);
        $display("seq sw_delayed: req_we=%0d done=%0d", req_we, done_n);

        // ---- FETCH timeout: 14 waits is fine, 15 faults ----
        do_reset();
        for (int k = 0; k < 14; k++) step();
        fetch(ADDI);
        @(negedge clk);
        check("fetch_14_waits_no_fault", 64'({state, fault}), 64'({3'd1, 1'b0}));
        $display("seq fetch_14_waits: state=%0d", state);
        step(); step(); step();          // DECODE -> EXEC -> WB -> FETCH
        stuck_to_fault(3'd0, "fetch_timeout");
        mem_ready = 1'b1;
        mem_rdata = ADDI;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            @(negedge clk);
            if (!(fault === 1'b1 && state === 3'd7 && mem_req === 1'b0)) bad++;
        end
        check("fault_sticky", 64'(bad), 64'd0);
        do_reset();
        @(negedge clk);
        check("fault_cleared_by_reset", 64'({state, fault, mem_req}), 64'({3'd0, 1'b0, 1'b1}));

        // ---- MEM timeout on a load ----
        do_reset();
        fetch(LW);
        step(); step();                  // DECODE -> EXEC -> MEM
        stuck_to_fault(3'd3, "mem_timeout");

        // ---- illegal opcode ----
        do_reset();
        fetch(32'h0000_0000);
        @(negedge clk);
        check("illegal_in_decode", 64'(state), 64'd1);
        step();
        @(negedge clk);
        check("illegal_fault", 64'({state, fault}), 64'({3'd7, 1'b1}));
        $display("seq illegal: state=%0d fault=%0b", state, fault);

        // ---- jal ----
        do_reset();
        fetch(JAL);
`ifdef MC_CONTROL_JAL_EN
        @(negedge clk);
        check("jal_decode_imm", 64'({state, imm_sel}), 64'({3'd1, 3'd3}));
        step();
        @(negedge clk);
        check("jal_exec", 64'({state, pc_write, pc_src, reg_write}), 64'({3'd2, 1'b1, 2'd2, 1'b0}));
        step();
        @(negedge clk);
        check("jal_wb", 64'({state, reg_write, wb_sel, instr_done}), 64'({3'd4, 1'b1, 2'd2, 1'b1}));
        step();
        @(negedge clk);
        check("jal_back_to_fetch", 64'(state), 64'd0);
`else
        step();
        @(negedge clk);
        check("jal_illegal_fault", 64'({state, fault, pc_write}), 64'({3'd7, 1'b1, 1'b0}));
`endif
        $display("seq jal: state=%0d fault=%0b", state, fault);

        // ---- reset asserted in the middle of MEM ----
        do_reset();
        fetch(LW);
        step(); step();                  // now in MEM, memory stalling
        @(negedge clk);
        check("pre_reset_in_mem", 64'({state, mem_req, mem_addr_sel}), 64'({3'd3, 1'b1, 1'b1}));
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_mid_mem", 64'({ir, state, mem_req, mem_we, mem_addr_sel, imm_sel, reg_write}),
              64'({NOP, 3'd0, 1'b0, 1'b0, 1'b0, 3'd7, 1'b0}));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("fetch_after_reset", 64'({state, mem_req, mem_addr_sel, mem_we}), 64'({3'd0, 1'b1, 1'b0, 1'b0}));
        $display("seq reset_mid_mem: state=%0d ir=%h", state, ir);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
